muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU. It is started by an M-extension instruction in EX and stalls the pipeline while it runs. One shift-add multiplier and one restoring divider share a single accumulator and a single iteration counter. The result is presented in the final cycle, which releases the stall so the instruction advances to EX/MEM with the product or quotient in place of the ALU result.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/muldiv_abs_neg.sv | 20 ++
 rtl/muldiv_sequencer.sv | 147 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared RV32M constants, sequencer state encoding and op helpers.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_abs_neg.sv
// ============================================================================
// Module  : muldiv_abs_neg
// Brief   : Conditional two's-complement negate (magnitude / sign restore).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Iterative RV32M multiply/divide unit with pipeline stall control.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall_out,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc, w_acc_step;
  logic [XLEN-1:0]   r_opb;
  logic [2:0]        r_op;
  logic              r_sign_a, r_sign_b;
  logic [XLEN-1:0]   r_result;

  logic            w_start, w_sa, w_sb, w_div_zero, w_ovf, w_special, w_cnt_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_result, w_quot, w_rem, w_final;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN:0]   w_rem_sh, w_diff, w_sum;
  logic            w_ge;

  assign w_start    = start && !flush;
  assign w_sa       = op_signed_a(funct3) & operand_a[XLEN-1];
  assign w_sb       = op_signed_b(funct3) & operand_b[XLEN-1];
  assign w_div_zero = funct3[2] && (operand_b == '0);
  assign w_ovf      = ((funct3 == DIV) || (funct3 == REM)) &&
                      (operand_a == C_MIN_NEG) && (operand_b == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_cnt_last = (r_cnt == CNT_W'(XLEN-1));

  always_comb begin
    w_special_result = '0;
    if (w_div_zero) w_special_result = funct3[1] ? operand_a : '1;
    else            w_special_result = funct3[1] ? '0 : C_MIN_NEG;
  end

  muldiv_abs_neg #(.W(XLEN)) u_abs_a (.value(operand_a), .neg(w_sa), .result(w_mag_a));
  muldiv_abs_neg #(.W(XLEN)) u_abs_b (.value(operand_b), .neg(w_sb), .result(w_mag_b));

  // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_ge       = (w_rem_sh >= {1'b0, r_opb});
    w_diff     = w_rem_sh - {1'b0, r_opb};
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_acc_step = {w_sum, r_acc[XLEN-1:1]};
    if (r_op[2]) begin
      w_acc_step = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    end
  end

  muldiv_abs_neg #(.W(2*XLEN)) u_neg_prod (
    .value(w_acc_step), .neg(r_sign_a ^ r_sign_b), .result(w_prod));
  muldiv_abs_neg #(.W(XLEN)) u_neg_quot (
    .value(w_acc_step[XLEN-1:0]), .neg(r_sign_a ^ r_sign_b), .result(w_quot));
  muldiv_abs_neg #(.W(XLEN)) u_neg_rem (
    .value(w_acc_step[2*XLEN-1:XLEN]), .neg(r_sign_a), .result(w_rem));

  always_comb begin
    case (r_op)
      MUL:         w_final = w_prod[XLEN-1:0];
      MULH, MULHSU,
      MULHU:       w_final = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:   w_final = w_quot;
      default:     w_final = w_rem;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    stall_out    = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        stall_out = w_start;
        if (w_start) w_state_next = w_special ? DONE : CALC;
      end
      CALC: begin
        stall_out = 1'b1;
        if (w_cnt_last) w_state_next = DONE;
      end
      DONE: begin
        done         = !flush;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_start) begin
        r_cnt    <= '0;
        r_op     <= funct3;
        r_sign_a <= w_sa;
        r_sign_b <= w_sb;
        r_opb    <= w_mag_b;
        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
        if (w_special) r_result <= w_special_result;
      end else if (r_state == CALC && !flush) begin
        r_acc <= w_acc_step;
        if (w_cnt_last) begin
          r_cnt    <= '0;
          r_result <= w_final;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Vector table, corner sequences and random ops vs arithmetic model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] C_MIN = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        stall_out, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall_out(stall_out), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Architectural RV32M semantics using wide integer arithmetic.
  function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == C_MIN && b == 32'hFFFFFFFF) return C_MIN;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == C_MIN && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic spec;
    spec = f3[2] && ((b == 0) || (!f3[0] && a == C_MIN && b == 32'hFFFFFFFF));
    return spec ? 1 : XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return C_MIN;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // start held for the whole instruction (as the pipeline does); operands wiggle after latch.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic stall_ok;
    lat = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
    #1;
    if (stall_out !== 1'b1) stall_ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        if (stall_out !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_out !== 1'b1) stall_ok = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
    end
    check({nm, ".lat"}, 32'(lat), 32'(exp_lat));
    check({nm, ".result"}, result, exp);
    check({nm, ".stall"}, {31'b0, stall_ok}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({nm, ".idle"}, {30'b0, done, stall_out}, 32'd0);
  endtask

  initial begin
    logic        seen_done;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{"mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"mulh_min",  3'b001, C_MIN,        C_MIN,        32'h40000000, 33};
    vecs[2]  = '{"mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{"div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{"rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{"divu",      3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{"remu",      3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{"divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{"rem_z",     3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{"div_ovf",   3'b100, C_MIN,        32'hFFFFFFFF, C_MIN,        1};
    vecs[11] = '{"rem_ovf",   3'b110, C_MIN,        32'hFFFFFFFF, 32'h0,        1};

    repeat (3) @(negedge clk);
    check("reset.stall", {31'b0, stall_out}, 32'd0);
    check("reset.done", {31'b0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // start together with flush is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd5; operand_b = 32'd6;
    #1;
    check("startflush.stall", {31'b0, stall_out}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("startflush.idle", {30'b0, done, stall_out}, 32'd0);

    // flush during CALC, then a fresh MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; operand_a = $urandom; operand_b = $urandom;
    seen_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    flush = 1'b1;
    #1;
    check("flush.calc_stall", {31'b0, stall_out}, 32'd1);
    check("flush.done_forced", {31'b0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush.stall_after", {31'b0, stall_out}, 32'd0);
    check("flush.no_done", {30'b0, seen_done, done}, 32'd0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // flush landing on the DONE cycle of a special case suppresses done
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; operand_a = 32'd5; operand_b = 32'd0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done.done", {31'b0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_done.idle", {30'b0, done, stall_out}, 32'd0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; operand_a = $urandom; operand_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.stall", {31'b0, stall_out}, 32'd0);
    check("arst.done", {31'b0, done}, 32'd0);
    check("arst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ref_muldiv(f3, a, b),
             ref_latency(f3, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
